// File: rtl/gerador_indices.sv
// Pseudo-random target-pattern generator for the hit comparator.
// Four 2-bit slots; code 00 marks a target. Patterns come from a 16-bit LFSR with a bounded target count.
module gerador_indices #(
    parameter int unsigned MIN_ALVOS = 1,
    parameter int unsigned MAX_ALVOS = 2,
    parameter int unsigned MAX_TENT  = 8,
    parameter logic [15:0] SEMENTE   = 16'hACE1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        gera,
    input  logic        limpa,
    input  logic        carrega_semente,
    input  logic [15:0] semente,
    output logic [7:0]  indices,
    output logic        pronto,
    output logic [2:0]  num_alvos
);

    localparam int unsigned LW = 16;
    localparam int unsigned IW = 8;
    localparam int unsigned NW = 3;
    localparam int unsigned TW = 4;

    localparam logic [TW-1:0] ULTIMA = TW'(MAX_TENT - 1);
    localparam logic [NW-1:0] MIN_N  = NW'(MIN_ALVOS);
    localparam logic [NW-1:0] MAX_N  = NW'(MAX_ALVOS);

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        GERA   = 2'd1,
        PRONTO = 2'd2
    } estado_t;

    estado_t        estado, estado_n;
    logic [LW-1:0]  lfsr, lfsr_n;
    logic [TW-1:0]  tent, tent_n;
    logic [IW-1:0]  indices_n;
    logic [NW-1:0]  num_n;
    logic           pronto_n;

    logic [IW-1:0]  cand;
    logic [NW-1:0]  n_cand;
    logic           aceita;

    // Maximal-length Fibonacci step (taps 16,14,13,11).
    function automatic logic [LW-1:0] passo(input logic [LW-1:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [NW-1:0] conta_alvos(input logic [IW-1:0] p);
        logic [NW-1:0] n;
        n = '0;
        for (int s = 0; s < 4; s++) begin
            if (p[2*s +: 2] == 2'b00) n = n + NW'(1);
        end
        return n;
    endfunction

    // Fallback: MIN_ALVOS consecutive slots (wrapping) from base are targets, the rest are 11.
    function automatic logic [IW-1:0] padrao_reserva(input logic [1:0] base);
        logic [IW-1:0] p;
        logic [1:0]    d;
        p = '1;
        for (int s = 0; s < 4; s++) begin
            d = 2'(s) - base;
            p[2*s +: 2] = (NW'(d) < MIN_N) ? 2'b00 : 2'b11;
        end
        return p;
    endfunction

    assign cand   = lfsr[7:0];
    assign n_cand = conta_alvos(cand);
    assign aceita = (n_cand >= MIN_N) && (n_cand <= MAX_N) && (cand != indices);

    // Next-state and output logic; seed load beats clear, clear beats generation.
    always_comb begin
        estado_n  = estado;
        lfsr_n    = lfsr;
        tent_n    = tent;
        indices_n = indices;
        num_n     = num_alvos;
        pronto_n  = pronto;

        if (carrega_semente) begin
            lfsr_n   = (semente == 16'h0000) ? SEMENTE : semente;
            tent_n   = '0;
            pronto_n = 1'b0;
            estado_n = OCIOSO;
        end else if (limpa) begin
            indices_n = 8'hFF;
            num_n     = '0;
            pronto_n  = 1'b0;
            tent_n    = '0;
            estado_n  = OCIOSO;
        end else begin
            unique case (estado)
                OCIOSO, PRONTO: begin
                    if (gera) begin
                        pronto_n = 1'b0;
                        lfsr_n   = passo(lfsr);
                        tent_n   = '0;
                        estado_n = GERA;
                    end
                end
                GERA: begin
                    if (aceita) begin
                        indices_n = cand;
                        num_n     = n_cand;
                        pronto_n  = 1'b1;
                        estado_n  = PRONTO;
                    end else if (tent < ULTIMA) begin
                        lfsr_n = passo(lfsr);
                        tent_n = tent + TW'(1);
                    end else begin
                        indices_n = padrao_reserva(lfsr[1:0]);
                        num_n     = MIN_N;
                        pronto_n  = 1'b1;
                        estado_n  = PRONTO;
                    end
                end
                default: estado_n = OCIOSO;
            endcase
        end
    end

    // State and output registers, synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            estado    <= OCIOSO;
            lfsr      <= SEMENTE;
            tent      <= '0;
            indices   <= 8'hFF;
            num_alvos <= '0;
            pronto    <= 1'b0;
        end else begin
            estado    <= estado_n;
            lfsr      <= lfsr_n;
            tent      <= tent_n;
            indices   <= indices_n;
            num_alvos <= num_n;
            pronto    <= pronto_n;
        end
    end

endmodule

// File: tb/tb_gerador_indices.sv
// Bench for gerador_indices: random gera traffic checked against a transaction-level pattern model.
module tb_gerador_indices;

    logic        clock = 1'b0;
    logic        reset;
    logic        gera, limpa, carrega_semente;
    logic [15:0] semente;
    logic [7:0]  indices;
    logic        pronto;
    logic [2:0]  num_alvos;

    logic        g2;
    logic [7:0]  ind2;
    logic        pr2;
    logic [2:0]  na2;

    int total = 0;
    int bad   = 0;

    logic [15:0] m_lfsr, m2_lfsr;
    logic [7:0]  m_ind, m2_ind;
    logic [7:0]  seq_a [20];
    logic [7:0]  seq_b [20];

    gerador_indices dut (
        .clock(clock), .reset(reset), .gera(gera), .limpa(limpa),
        .carrega_semente(carrega_semente), .semente(semente),
        .indices(indices), .pronto(pronto), .num_alvos(num_alvos)
    );

    gerador_indices #(.MIN_ALVOS(4), .MAX_ALVOS(4), .MAX_TENT(2)) dut4 (
        .clock(clock), .reset(reset), .gera(g2), .limpa(1'b0),
        .carrega_semente(1'b0), .semente(16'h0000),
        .indices(ind2), .pronto(pr2), .num_alvos(na2)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [15:0] m_step(input logic [15:0] l);
        int v, fb;
        v  = int'(l);
        fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
        return 16'(((v * 2) + fb) % 65536);
    endfunction

    function automatic int m_zeros(input logic [7:0] p);
        int z, pv;
        z  = 0;
        pv = int'(p);
        for (int i = 0; i < 4; i++) if (((pv >> (2 * i)) & 3) == 0) z++;
        return z;
    endfunction

    // One whole generation request: resulting pattern, count and edges-to-ready.
    task automatic model_gen(input int mn, input int mx, input int mt,
                             input logic [15:0] l_in, input logic [7:0] ind_in,
                             output logic [15:0] l_out, output logic [7:0] ind_out,
                             output int cyc, output int n, output bit fb);
        logic [15:0] l;
        int z, pat, slot;
        bit done;
        l = m_step(l_in);
        done = 0; fb = 0; cyc = 0; n = 0; ind_out = ind_in;
        for (int t = 0; t < mt && !done; t++) begin
            z = m_zeros(l[7:0]);
            if (z >= mn && z <= mx && l[7:0] != ind_in) begin
                ind_out = l[7:0]; n = z; cyc = t + 1; done = 1;
            end else if (t < mt - 1) begin
                l = m_step(l);
            end else begin
                pat = 255;
                for (int k = 0; k < mn; k++) begin
                    slot = (int'(l[1:0]) + k) % 4;
                    pat = pat & ~(3 << (2 * slot));
                end
                ind_out = 8'(pat); n = mn; cyc = mt; fb = 1; done = 1;
            end
        end
        l_out = l;
    endtask

    task automatic run_gera(input string tag);
        int c, cyc, n;
        bit fb;
        logic [7:0] prev;
        prev = m_ind;
        model_gen(1, 2, 8, m_lfsr, m_ind, m_lfsr, m_ind, cyc, n, fb);
        gera = 1'b1; tick(); gera = 1'b0;
        c = 0;
        while (!pronto && c < 20) begin tick(); c++; end
        check({tag, " latency"}, c, cyc);
        check({tag, " indices"}, int'(indices), int'(m_ind));
        check({tag, " num_alvos"}, int'(num_alvos), n);
        if (!fb) check({tag, " no-repeat"}, int'(indices != prev), 1);
    endtask

    task automatic run_gera4(input string tag);
        int c, cyc, n;
        bit fb;
        model_gen(4, 4, 2, m2_lfsr, m2_ind, m2_lfsr, m2_ind, cyc, n, fb);
        g2 = 1'b1; tick(); g2 = 1'b0;
        c = 0;
        while (!pr2 && c < 10) begin tick(); c++; end
        check({tag, " latency"}, c, cyc);
        check({tag, " indices"}, int'(ind2), int'(m2_ind));
        check({tag, " num_alvos"}, int'(na2), n);
    endtask

    // Clear, then load a seed, so runs from equal seeds start from identical state.
    task automatic seed_load(input logic [15:0] s);
        limpa = 1'b1; tick(); limpa = 1'b0;
        m_ind = 8'hFF;
        carrega_semente = 1'b1; semente = s; tick(); carrega_semente = 1'b0;
        m_lfsr = (s == 16'h0) ? 16'hACE1 : s;
        check("seed pronto", int'(pronto), 0);
        check("seed indices", int'(indices), 8'hFF);
    endtask

    initial begin
        int cyc, n, diffs;
        bit fb;
        logic [7:0]  keep;
        logic [15:0] s;

        reset = 1'b0; gera = 1'b0; limpa = 1'b0; carrega_semente = 1'b0;
        semente = 16'h0; g2 = 1'b0;

        // Reset held two cycles
        tick(); tick();
        reset = 1'b1;
        m_lfsr = 16'hACE1; m_ind = 8'hFF;
        m2_lfsr = 16'hACE1; m2_ind = 8'hFF;
        check("rst indices", int'(indices), 8'hFF);
        check("rst pronto", int'(pronto), 0);
        check("rst num_alvos", int'(num_alvos), 0);
        repeat (5) tick();
        check("idle indices", int'(indices), 8'hFF);
        check("idle pronto", int'(pronto), 0);

        // Random-gap gera traffic with defaults
        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            run_gera("gen");
        end

        // Seed reproducibility
        seed_load(16'h0000);
        for (int i = 0; i < 20; i++) begin run_gera("seed0"); seq_a[i] = indices; end
        seed_load(16'hACE1);
        for (int i = 0; i < 20; i++) begin run_gera("seedace1"); seq_b[i] = indices; end
        diffs = 0;
        for (int i = 0; i < 20; i++) if (seq_a[i] != seq_b[i]) diffs++;
        check("seq 0 vs ACE1 diffs", diffs, 0);
        seed_load(16'h1234);
        for (int i = 0; i < 20; i++) begin run_gera("seed1234"); seq_b[i] = indices; end
        diffs = 0;
        for (int i = 0; i < 20; i++) if (seq_a[i] != seq_b[i]) diffs++;
        check("seq 1234 differs", int'(diffs > 0), 1);

        for (int r = 0; r < 3; r++) begin
            seed_load(16'($urandom));
            for (int i = 0; i < 10; i++) run_gera("rndseed");
        end

        // All-target configuration with short retry budget
        for (int i = 0; i < 10; i++) run_gera4("four");
        check("four pattern", int'(ind2), 8'h00);

        // Extra gera pulses while generating are ignored
        for (int i = 0; i < 10; i++) begin
            model_gen(1, 2, 8, m_lfsr, m_ind, m_lfsr, m_ind, cyc, n, fb);
            gera = 1'b1; tick();
            for (int k = 1; k <= cyc; k++) begin
                gera = 1'($urandom_range(0, 1)); tick();
            end
            gera = 1'b0;
            check("noisy pronto", int'(pronto), 1);
            check("noisy indices", int'(indices), int'(m_ind));
            check("noisy num_alvos", int'(num_alvos), n);
            repeat (3) tick();
            check("noisy held pronto", int'(pronto), 1);
            check("noisy held indices", int'(indices), int'(m_ind));
        end

        // limpa during generation
        gera = 1'b1; tick(); gera = 1'b0;
        m_lfsr = m_step(m_lfsr);
        limpa = 1'b1; tick(); limpa = 1'b0;
        m_ind = 8'hFF;
        check("limpa indices", int'(indices), 8'hFF);
        check("limpa pronto", int'(pronto), 0);
        check("limpa num_alvos", int'(num_alvos), 0);
        repeat (3) tick();
        check("limpa idle pronto", int'(pronto), 0);
        run_gera("after limpa");

        // Seed load and gera together in PRONTO: seed wins
        keep = m_ind;
        s = 16'($urandom_range(1, 65535));
        carrega_semente = 1'b1; gera = 1'b1; semente = s; tick();
        carrega_semente = 1'b0; gera = 1'b0;
        m_lfsr = s;
        check("seed+gera pronto", int'(pronto), 0);
        check("seed+gera indices", int'(indices), int'(keep));
        repeat (3) tick();
        check("seed+gera no gen", int'(pronto), 0);
        run_gera("after seed+gera");

        // Reset in the middle of generation
        gera = 1'b1; tick(); gera = 1'b0;
        reset = 1'b0; tick(); reset = 1'b1;
        m_lfsr = 16'hACE1; m_ind = 8'hFF;
        m2_lfsr = 16'hACE1; m2_ind = 8'hFF;
        check("midrst indices", int'(indices), 8'hFF);
        check("midrst pronto", int'(pronto), 0);
        check("midrst num_alvos", int'(num_alvos), 0);
        run_gera("after midrst");
        run_gera4("four after rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gerador_indices.md
Name: gerador_indices

Overview:
- Generates the 8-bit `indices` pattern that the game's hit comparator consumes: 4 slots × 2-bit codes, slot 3 in bits [7:6] down to slot 0 in bits [1:0].
- A code of 00 marks a target slot; any other code marks a non-target slot.
- Sits between the game controller FSM and the comparator. On each `gera` request it produces a fresh pseudo-random pattern from a 16-bit LFSR, with the number of targets bounded, and raises `pronto` when the pattern is stable.

Parameters:
- MIN_ALVOS, 1, minimum number of 00 slots per pattern (1 ≤ MIN_ALVOS ≤ MAX_ALVOS).
- MAX_ALVOS, 2, maximum number of 00 slots per pattern (≤ 4).
- MAX_TENT, 8, LFSR candidates tried before fallback (1..15; 4-bit counter).
- SEMENTE, 16'hACE1, LFSR reset value; must be non-zero.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset.
- gera  in  1  request a new pattern; sampled in OCIOSO/PRONTO only.
- limpa  in  1  clear the pattern (no targets shown).
- carrega_semente  in  1  load `semente` into the LFSR.
- semente  in  16  seed value; 0 is replaced by SEMENTE.
- indices  out  8  current pattern, held stable while `pronto`=1.
- pronto  out  1  `indices` valid and stable.
- num_alvos  out  3  count of 00 slots in `indices` (0..4), registered with `indices`.

Behaviour:
- Reset (reset=0 at edge):
  - lfsr = SEMENTE, indices = 8'hFF, pronto = 0, num_alvos = 0, tent = 0, state = OCIOSO.
  - Reset overrides every other input, in every state.
- LFSR step: lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}. This is maximal-length, so it never reaches 0.
- Priority, highest first: reset, carrega_semente, limpa, gera.
- carrega_semente=1, any state:
  - lfsr <= (semente==0 ? SEMENTE : semente); tent <= 0; pronto <= 0; state <= OCIOSO.
  - indices and num_alvos are unchanged.
- limpa=1, any state: indices <= 8'hFF; num_alvos <= 0; pronto <= 0; tent <= 0; state <= OCIOSO.
- OCIOSO or PRONTO with gera=1: pronto <= 0; LFSR steps; tent <= 0; state <= GERA.
- GERA, evaluated each cycle:
  - Inputs ignored: gera is ignored; limpa and carrega_semente still apply.
  - Candidate: cand = lfsr[7:0]; n = number of 2-bit slots of cand equal to 00.
  - Accept when MIN_ALVOS ≤ n ≤ MAX_ALVOS and cand ≠ current indices.
    - indices <= cand; num_alvos <= n; pronto <= 1; state <= PRONTO.
  - Reject when tent < MAX_TENT-1: LFSR steps; tent <= tent+1; stay in GERA.
  - Reject when tent == MAX_TENT-1 (fallback):
    - Slots (lfsr[1:0] + k) mod 4, for k = 0..MIN_ALVOS-1, are set to 00; all other slots are set to 11.
    - num_alvos <= MIN_ALVOS; pronto <= 1; state <= PRONTO.
    - The fallback is exempt from the no-repeat rule.
- Latency:
  - gera sampled at edge E0; first candidate evaluated at E1.
  - pronto is high after E1 at best and after E(MAX_TENT) at worst.
- PRONTO: indices, num_alvos and pronto are held until gera, limpa, carrega_semente or reset.
- Invariant whenever pronto=1: num_alvos == number of 00 slots in indices, and MIN_ALVOS ≤ num_alvos ≤ MAX_ALVOS.

Test Plan:
1. Reset held for 2 cycles, then released → indices=8'hFF, pronto=0, num_alvos=0, no change without stimulus.
2. Defaults; 200 single-cycle gera pulses, each issued after pronto=1:
   - pronto rises 1..8 cycles after each pulse.
   - num_alvos ∈ {1,2} and matches the 00 count of indices.
   - No two consecutive patterns are equal unless the pattern came from the fallback.
3. carrega_semente with semente=0, then 20 geras logged; repeat with semente=16'hACE1 → identical 20-pattern sequences. Repeat with semente=16'h1234 → a different sequence.
4. MIN_ALVOS=MAX_ALVOS=4, MAX_TENT=2 → every gera yields indices=8'h00, num_alvos=4, pronto within 2 cycles.
5. Mid-GERA events:
   - Extra gera pulses during GERA → ignored; exactly one pattern is produced.
   - limpa asserted in GERA → next cycle indices=8'hFF, pronto=0, state OCIOSO.
6. Simultaneous events:
   - carrega_semente and gera in the same cycle in PRONTO → seed loaded, pronto=0, no generation.
   - reset=0 asserted mid-GERA → all outputs return to their reset values at that edge.
